ftb_update_ctrl: RTL and testbench

// - Write-side initiator for the FTB set-assoc SRAM: queues committed FTB updates, drives the FTB update/write port.
// - Per entry: update-lookup (way select) then write, 2-cycle fixed transaction; yields to frontend lookups with bounded deferral.
// - Sits between backend commit (ftbInfo_t producer) and the FTB storage inside the branch predictor.

---
 rtl/ftb_update_ctrl_pkg.sv | 29 ++
 rtl/ftb_update_ctrl_queue.sv | 57 +++++
 rtl/ftb_update_ctrl.sv | 132 +++++++++++++
 tb/tb_ftb_update_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ftb_update_ctrl_pkg.sv
// Shared frontend types for the FTB update path.
//   XLEN / FTB_TAG_WIDTH : address and tag widths
//   ftbInfo_t            : FTB entry content written into the set-assoc SRAM
//   ftbUpdReq_t          : one queued update (fetch-block pc + new entry content)
//   ftbUpdState_t        : update-port FSM states
package ftb_update_ctrl_pkg;

    localparam int XLEN          = 32;
    localparam int FTB_TAG_WIDTH = 20;

    typedef struct packed {
        logic                     valid;
        logic [FTB_TAG_WIDTH-1:0] tag;
        logic [3:0]               br_offset;
        logic [XLEN-1:0]          target;
    } ftbInfo_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        ftbInfo_t        info;
    } ftbUpdReq_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } ftbUpdState_t;

endpackage

// File: rtl/ftb_update_ctrl_queue.sv
// ftb_upd_queue: DEPTH-entry circular buffer of pending FTB updates.
//   clk, rst   : clock, synchronous active-high reset (flushes pointers)
//   enq        : push enq_data into a new slot
//   ovr        : overwrite info of the newest entry in place (no new slot)
//   deq        : pop head
//   head, tail : oldest / newest entry
//   empty/full : occupancy flags, count : number of valid entries
// Pointers carry one extra MSB so full and empty are distinguishable.
module ftb_upd_queue
    import ftb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       ovr,
    input  ftbUpdReq_t                 enq_data,
    input  logic                       deq,
    output ftbUpdReq_t                 head,
    output ftbUpdReq_t                 tail,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    ftbUpdReq_t    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] tail_idx;

    assign tail_idx = wr_ptr[AW-1:0] - AW'(1);
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (count == (AW+1)'(DEPTH));
    assign head     = mem[rd_ptr[AW-1:0]];
    assign tail     = mem[tail_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr[AW-1:0]] <= enq_data;
        else if (ovr)
            mem[tail_idx].info <= enq_data.info;
    end

endmodule

// File: rtl/ftb_update_ctrl.sv
// ftb_update_ctrl: write-side initiator for the FTB set-assoc SRAM.
// Queues committed FTB updates and runs each one as a fixed 2-cycle
// READ (way select) + WRITE transaction on the FTB update port. Pending
// updates yield to frontend lookups for at most MAX_DEFER cycles; a full
// queue forces the start.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_commit_vld/o_commit_rdy  commit handshake (rdy = !full)
//   i_commit_pc/i_commit_info  update content
//   i_lookup_req               frontend lookup pending this cycle
//   o_ftb_update_req/_pc       update port request (READ and WRITE cycles)
//   i_ftb_update_sel_vec       one-hot way from the FTB (hit or replacement)
//   o_ftb_write_req/_way_vec/_info  write strobe, way and data
//   o_busy                     FTB port taken by the update path
// Build option: FTB_UPD_COALESCE_EN merges a commit with the same pc as the
// newest queued (unlocked) entry by overwriting its info in place.
module ftb_update_ctrl
    import ftb_update_ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WAYS      = 4,
    parameter int MAX_DEFER = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_commit_vld,
    output logic            o_commit_rdy,
    input  logic [XLEN-1:0] i_commit_pc,
    input  ftbInfo_t        i_commit_info,
    input  logic            i_lookup_req,
    output logic            o_ftb_update_req,
    output logic [XLEN-1:0] o_ftb_update_pc,
    input  logic [WAYS-1:0] i_ftb_update_sel_vec,
    output logic            o_ftb_write_req,
    output logic [WAYS-1:0] o_ftb_write_way_vec,
    output ftbInfo_t        o_ftb_write_info,
    output logic            o_busy
);
    localparam int DW = $clog2(MAX_DEFER + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    ftbUpdState_t  state, state_nxt;
    logic [DW-1:0] defer_cnt, defer_nxt;
    ftbUpdReq_t    head;
    logic [CW-1:0] count;
    logic          empty, full, accept, enq, ovr, deq, start;

    assign o_commit_rdy = !full;
    assign accept       = i_commit_vld && o_commit_rdy;

`ifdef FTB_UPD_COALESCE_EN
    ftbUpdReq_t tail;
    logic       tail_locked;
    // The newest entry is the in-flight head only when it is the sole entry.
    assign tail_locked = (state != IDLE) && (count == CW'(1));
    assign ovr = accept && !empty && !tail_locked && (tail.pc == i_commit_pc);
    assign enq = accept && !ovr;
`else
    assign ovr = 1'b0;
    assign enq = accept;
`endif

    ftb_upd_queue #(.DEPTH(DEPTH)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .enq      (enq),
        .ovr      (ovr),
        .enq_data ('{pc: i_commit_pc, info: i_commit_info}),
        .deq      (deq),
        .head     (head),
`ifdef FTB_UPD_COALESCE_EN
        .tail     (tail),
`else
        .tail     (),
`endif
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    assign start = !empty && (!i_lookup_req || defer_cnt == DW'(MAX_DEFER) || full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            defer_cnt <= '0;
        end else begin
            state     <= state_nxt;
            defer_cnt <= defer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        defer_nxt = defer_cnt;
        deq       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                    defer_nxt = '0;
                end else if (!empty && i_lookup_req) begin
                    // start fires once the count hits MAX_DEFER, so this saturates.
                    defer_nxt = defer_cnt + 1'b1;
                end
            end
            READ: state_nxt = WRITE;
            WRITE: begin
                deq = 1'b1;
                // count is pre-dequeue; >1 means another entry remains behind the head.
                if (count > CW'(1) && start) begin
                    state_nxt = READ;
                    defer_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_ftb_update_req    = (state != IDLE);
    assign o_ftb_write_req     = (state == WRITE);
    assign o_ftb_update_pc     = o_ftb_update_req ? head.pc : '0;
    assign o_ftb_write_way_vec = o_ftb_write_req ? i_ftb_update_sel_vec : '0;
    assign o_ftb_write_info    = o_ftb_write_req ? head.info : '0;
    assign o_busy              = o_ftb_update_req;

    a_sel_onehot: assert property (@(posedge clk) disable iff (rst)
        (state == WRITE) |-> $onehot(i_ftb_update_sel_vec));

endmodule

// File: tb/tb_ftb_update_ctrl.sv
module tb_ftb_update_ctrl;
    import ftb_update_ctrl_pkg::*;

    localparam int DEPTH = 4, WAYS = 4, MAX_DEFER = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            vld, rdy, lookup, upd_req, wr_req, busy;
    logic [XLEN-1:0] pc, upd_pc;
    ftbInfo_t        info, wr_info;
    logic [WAYS-1:0] sel, wr_way;

    int n_chk = 0, n_fail = 0, busy_n, idle_n;
    logic [XLEN-1:0] wr_pc_q[$];
    ftbInfo_t        wr_info_q[$];

    always #5 clk = ~clk;

    ftb_update_ctrl #(.DEPTH(DEPTH), .WAYS(WAYS), .MAX_DEFER(MAX_DEFER)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_commit_vld         (vld),
        .o_commit_rdy         (rdy),
        .i_commit_pc          (pc),
        .i_commit_info        (info),
        .i_lookup_req         (lookup),
        .o_ftb_update_req     (upd_req),
        .o_ftb_update_pc      (upd_pc),
        .i_ftb_update_sel_vec (sel),
        .o_ftb_write_req      (wr_req),
        .o_ftb_write_way_vec  (wr_way),
        .o_ftb_write_info     (wr_info),
        .o_busy               (busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic ftbInfo_t mk_info(input int k);
        ftbInfo_t f;
        f.valid     = 1'b1;
        f.tag       = FTB_TAG_WIDTH'(k * 32'h111);
        f.br_offset = 4'(k);
        f.target    = XLEN'(32'h8000 + k * 4);
        return f;
    endfunction

    // Observe n cycles (sampled on negedge), logging busy cycles and writes.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (upd_req) busy_n++;
            if (wr_req) begin
                wr_pc_q.push_back(upd_pc);
                wr_info_q.push_back(wr_info);
            end
        end
    endtask

    task automatic clr_log();
        busy_n = 0;
        wr_pc_q.delete();
        wr_info_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vld = 1'b0; pc = '0; info = '0; lookup = 1'b0; sel = 4'b0100;
        repeat (2) @(negedge clk);
        chk("rst_rdy",  rdy, 1);
        chk("rst_upd",  upd_req, 0);
        chk("rst_wr",   wr_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_way",  wr_way, 0);
        chk("rst_info", wr_info, 0);
        rst = 1'b0;

        // Single update, no lookups: IDLE (entry visible), READ, WRITE, IDLE.
        vld = 1'b1; pc = 32'h1000; info = mk_info(1);
        @(negedge clk); vld = 1'b0;
        chk("t1_idle_upd", upd_req, 0);
        @(negedge clk);
        chk("t1_read_upd", upd_req, 1);
        chk("t1_read_wr",  wr_req, 0);
        chk("t1_read_pc",  upd_pc, 32'h1000);
        @(negedge clk);
        chk("t1_wr_upd",  upd_req, 1);
        chk("t1_wr_req",  wr_req, 1);
        chk("t1_wr_pc",   upd_pc, 32'h1000);
        chk("t1_wr_way",  wr_way, 4'b0100);
        chk("t1_wr_info", wr_info, mk_info(1));
        chk("t1_wr_busy", busy, 1);
        @(negedge clk);
        chk("t1_done_upd", upd_req, 0);
        chk("t1_done_wr",  wr_req, 0);

        // Deferral: 8 yielding cycles plus the start-decision cycle before READ.
        lookup = 1'b1; vld = 1'b1; pc = 32'h1100; info = mk_info(2);
        @(negedge clk); vld = 1'b0;
        idle_n = 0;
        for (int i = 0; i < 30 && !upd_req; i++) begin
            idle_n++;
            @(negedge clk);
        end
        chk("t2_started",   upd_req, 1);
        chk("t2_idle_cyc",  idle_n, MAX_DEFER + 1);
        chk("t2_read_pc",   upd_pc, 32'h1100);
        @(negedge clk);
        chk("t2_wr_req",  wr_req, 1);
        chk("t2_wr_info", wr_info, mk_info(2));
        @(negedge clk);
        chk("t2_done", upd_req, 0);

        // Fill the queue under lookups: forced start, rejected commits while full.
        for (int k = 0; k < 4; k++) begin
            vld = 1'b1; pc = 32'h3000 + k * 64; info = mk_info(16 + k);
            @(negedge clk);
        end
        chk("t3_full_rdy", rdy, 0);
        chk("t3_full_upd", upd_req, 0);
        pc = 32'h3100; info = mk_info(31);
        clr_log();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("t3_forced_read", upd_req, 1);
                chk("t3_forced_wr",   wr_req, 0);
            end
            if (i < 2) chk($sformatf("t3_rdy_full_%0d", i), rdy, 0);
            if (i == 2) begin
                chk("t3_rdy_after_deq", rdy, 1);
                vld = 1'b0;
            end
            if (upd_req) busy_n++;
            if (wr_req) begin
                wr_pc_q.push_back(upd_pc);
                wr_info_q.push_back(wr_info);
            end
        end
        chk("t3_busy_cyc", busy_n, 8);
        chk("t3_n_writes", wr_pc_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_pc_%0d", k), (wr_pc_q.size() > k) ? wr_pc_q[k] : '0, 32'h3000 + k * 64);
            chk($sformatf("t3_info_%0d", k), (wr_info_q.size() > k) ? wr_info_q[k] : '0, mk_info(16 + k));
        end

        // Same pc committed twice while deferred.
        vld = 1'b1; pc = 32'h2000; info = mk_info(5);
        @(negedge clk);
        info = mk_info(6);
        @(negedge clk);
        vld = 1'b0; lookup = 1'b0;
        clr_log();
        watch(12);
`ifdef FTB_UPD_COALESCE_EN
        chk("t4_n_writes", wr_pc_q.size(), 1);
        chk("t4_pc0",   (wr_pc_q.size() > 0) ? wr_pc_q[0] : '0, 32'h2000);
        chk("t4_info0", (wr_info_q.size() > 0) ? wr_info_q[0] : '0, mk_info(6));
        chk("t4_busy",  busy_n, 2);
`else
        chk("t4_n_writes", wr_pc_q.size(), 2);
        chk("t4_pc0",   (wr_pc_q.size() > 0) ? wr_pc_q[0] : '0, 32'h2000);
        chk("t4_info0", (wr_info_q.size() > 0) ? wr_info_q[0] : '0, mk_info(5));
        chk("t4_pc1",   (wr_pc_q.size() > 1) ? wr_pc_q[1] : '0, 32'h2000);
        chk("t4_info1", (wr_info_q.size() > 1) ? wr_info_q[1] : '0, mk_info(6));
        chk("t4_busy",  busy_n, 4);
`endif

        // Reset while READ is in flight: no write follows, queue flushed.
        vld = 1'b1; pc = 32'h5000; info = mk_info(7);
        @(negedge clk);
        pc = 32'h5040; info = mk_info(8);
        @(negedge clk);
        vld = 1'b0;
        chk("t5_in_read_upd", upd_req, 1);
        chk("t5_in_read_wr",  wr_req, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_wr",  wr_req, 0);
        chk("t5_rst_upd", upd_req, 0);
        chk("t5_rst_rdy", rdy, 1);
        rst = 1'b0;
        clr_log();
        watch(6);
        chk("t5_empty_busy",   busy_n, 0);
        chk("t5_empty_writes", wr_pc_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
